sr_cmd_gen: RTL and testbench

//  Upstream command stage for the sr_ff block: turns two raw, asynchronous, bouncy

---
 rtl/sr_cmd_gen.sv | 155 +++++++++++++++
 tb/tb_sr_cmd_gen.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sr_cmd_gen.sv
// sr_cmd_gen: sync, debounce, edge-detect and arbitrate set/clear requests
// into clean non-overlapping s/r pulses for the sr_ff block.
`timescale 1ns/1ps
module sr_cmd_gen #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int PULSE_CYCLES    = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic set_btn,
    input  logic clr_btn,
    output logic s,
    output logic r,
    output logic busy,
    output logic conflict
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PW = $clog2(PULSE_CYCLES + 1);
    localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [PW-1:0] P_LAST = PW'(PULSE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        PULSE_S,
        PULSE_R,
        GAP
    } state_t;

    // Channel 0 is set, channel 1 is clear.
    logic [1:0]    raw;
    logic [1:0]    sync1_q;
    logic [1:0]    sync2_q;
    logic [1:0]    deb_q;
    logic [1:0]    deb_d;
    logic [1:0]    req_q;
    logic [1:0]    req_d;
    logic [DW-1:0] cnt_q [2];
    logic [DW-1:0] cnt_d [2];

    state_t        state_q;
    state_t        state_d;
    logic [PW-1:0] pcnt_q;
    logic [PW-1:0] pcnt_d;
    logic          pend_s_q;
    logic          pend_s_d;
    logic          pend_r_q;
    logic          pend_r_d;
    logic          s_q;
    logic          r_q;
    logic          busy_q;
    logic          conflict_q;

    logic          new_s;
    logic          new_r;
    logic          want_s;
    logic          want_r;

    assign raw = {clr_btn, set_btn};

    // Debounce: accept a level after DEBOUNCE_CYCLES differing cycles;
    // a request is raised only when the accepted level rises.
    always_comb begin
        deb_d = deb_q;
        req_d = '0;
        for (int i = 0; i < 2; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == D_LAST) begin
                    deb_d[i] = sync2_q[i];
                    req_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Arbitration and pulse sequencing. GAP re-arbitrates directly so a
    // waiting request follows after exactly one idle cycle.
    always_comb begin
        new_r    = req_q[1];
        new_s    = req_q[0] & ~req_q[1];
        want_r   = pend_r_q | new_r;
        want_s   = pend_s_q | new_s;
        state_d  = state_q;
        pcnt_d   = pcnt_q;
        pend_r_d = want_r;
        pend_s_d = want_s;
        case (state_q)
            IDLE, GAP: begin
                if (want_r) begin
                    state_d  = PULSE_R;
                    pend_r_d = 1'b0;
                    pcnt_d   = '0;
                end else if (want_s) begin
                    state_d  = PULSE_S;
                    pend_s_d = 1'b0;
                    pcnt_d   = '0;
                end else begin
                    state_d  = IDLE;
                end
            end
            PULSE_S, PULSE_R: begin
                if (pcnt_q == P_LAST) begin
                    state_d = GAP;
                end else begin
                    pcnt_d = pcnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, synchronisers, debounce counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            req_q      <= '0;
            cnt_q[0]   <= '0;
            cnt_q[1]   <= '0;
            state_q    <= IDLE;
            pcnt_q     <= '0;
            pend_s_q   <= 1'b0;
            pend_r_q   <= 1'b0;
            s_q        <= 1'b0;
            r_q        <= 1'b0;
            busy_q     <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            sync1_q    <= raw;
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            req_q      <= req_d;
            cnt_q[0]   <= cnt_d[0];
            cnt_q[1]   <= cnt_d[1];
            state_q    <= state_d;
            pcnt_q     <= pcnt_d;
            pend_s_q   <= pend_s_d;
            pend_r_q   <= pend_r_d;
            s_q        <= (state_d == PULSE_S);
            r_q        <= (state_d == PULSE_R);
            busy_q     <= (state_d != IDLE);
            conflict_q <= req_q[0] & req_q[1];
        end
    end

    assign s        = s_q;
    assign r        = r_q;
    assign busy     = busy_q;
    assign conflict = conflict_q;

endmodule

// File: tb/tb_sr_cmd_gen.sv
// tb_sr_cmd_gen: directed and random stimulus on two sr_cmd_gen
// instances (pulse width 1 and 3) checked against a timeline model.
`timescale 1ns/1ps
module tb_sr_cmd_gen;

    localparam int D    = 4;
    localparam int MAXC = 4096;

    logic clk;
    logic rst;
    logic set_btn;
    logic clr_btn;
    logic s1, r1, b1, c1;
    logic s3, r3, b3, c3;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    bit sy1 [2][MAXC];
    bit sy2 [2][MAXC];
    bit deb  [2];
    bit reqp [2];

    int rem    [2];
    bit chr    [2];
    bit pend_s [2];
    bit pend_r [2];
    bit exp_s  [2];
    bit exp_r  [2];
    bit exp_b  [2];
    bit exp_c  [2];

    int cnt_s1, cnt_r1, cnt_c1, cnt_s3, cnt_r3;

    sr_cmd_gen #(
        .DEBOUNCE_CYCLES(D),
        .PULSE_CYCLES   (1)
    ) u_dut_p1 (
        .clk     (clk),
        .rst     (rst),
        .set_btn (set_btn),
        .clr_btn (clr_btn),
        .s       (s1),
        .r       (r1),
        .busy    (b1),
        .conflict(c1)
    );

    sr_cmd_gen #(
        .DEBOUNCE_CYCLES(D),
        .PULSE_CYCLES   (3)
    ) u_dut_p3 (
        .clk     (clk),
        .rst     (rst),
        .set_btn (set_btn),
        .clr_btn (clr_btn),
        .s       (s3),
        .r       (r3),
        .busy    (b3),
        .conflict(c3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(string tag, int got, int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    // Model of one clock edge. A level is accepted once the synchronised
    // input has shown the opposite value on each of the last D cycles; a
    // request made at one edge is acted on at the next. Each served
    // request occupies P pulse cycles plus one gap cycle, and a new one
    // may start on the gap's closing edge.
    task automatic model_edge(bit rs, bit sb, bit cb);
        bit raw [2];
        bit flip;
        bit rq_s, rq_r, ns, ws, wr;
        int p;
        raw[0] = sb;
        raw[1] = cb;
        cyc++;
        rq_s = reqp[0];
        rq_r = reqp[1];
        for (int ch = 0; ch < 2; ch++) begin
            if (rs) begin
                sy1[ch][cyc] = 1'b0;
                sy2[ch][cyc] = 1'b0;
                deb[ch]      = 1'b0;
                reqp[ch]     = 1'b0;
            end else begin
                sy2[ch][cyc] = sy1[ch][cyc-1];
                sy1[ch][cyc] = raw[ch];
                flip = (cyc > D);
                for (int k = 1; k <= D; k++)
                    if (cyc >= k && sy2[ch][cyc-k] == deb[ch])
                        flip = 1'b0;
                reqp[ch] = flip && !deb[ch];
                if (flip) deb[ch] = !deb[ch];
            end
        end
        for (int i = 0; i < 2; i++) begin
            p = (i == 0) ? 1 : 3;
            if (rs) begin
                rem[i]    = 0;
                chr[i]    = 1'b0;
                pend_s[i] = 1'b0;
                pend_r[i] = 1'b0;
                exp_c[i]  = 1'b0;
            end else begin
                exp_c[i] = rq_s && rq_r;
                ns = rq_s && !rq_r;
                ws = pend_s[i] || ns;
                wr = pend_r[i] || rq_r;
                if (rem[i] <= 1 && (ws || wr)) begin
                    chr[i]    = wr;
                    rem[i]    = p + 1;
                    pend_r[i] = 1'b0;
                    pend_s[i] = wr ? ws : 1'b0;
                end else begin
                    if (rem[i] > 0) rem[i]--;
                    pend_s[i] = ws;
                    pend_r[i] = wr;
                end
            end
            exp_s[i] = (rem[i] > 1) && !chr[i];
            exp_r[i] = (rem[i] > 1) && chr[i];
            exp_b[i] = (rem[i] > 0);
        end
    endtask

    task automatic step(bit rs, bit sb, bit cb);
        rst     = rs;
        set_btn = sb;
        clr_btn = cb;
        @(posedge clk);
        if (cyc + 1 >= MAXC) begin
            $display("FAIL cycle_budget: got %0d expected <%0d", cyc, MAXC);
            $fatal(1, "cycle budget exhausted");
        end
        model_edge(rs, sb, cb);
        #1;
        check("s_p1", int'(s1), int'(exp_s[0]));
        check("r_p1", int'(r1), int'(exp_r[0]));
        check("busy_p1", int'(b1), int'(exp_b[0]));
        check("conflict_p1", int'(c1), int'(exp_c[0]));
        check("s_and_r_p1", int'(s1 & r1), 0);
        check("s_p3", int'(s3), int'(exp_s[1]));
        check("r_p3", int'(r3), int'(exp_r[1]));
        check("busy_p3", int'(b3), int'(exp_b[1]));
        check("conflict_p3", int'(c3), int'(exp_c[1]));
        check("s_and_r_p3", int'(s3 & r3), 0);
        cnt_s1 += int'(s1);
        cnt_r1 += int'(r1);
        cnt_c1 += int'(c1);
        cnt_s3 += int'(s3);
        cnt_r3 += int'(r3);
    endtask

    task automatic clr_counts();
        cnt_s1 = 0;
        cnt_r1 = 0;
        cnt_c1 = 0;
        cnt_s3 = 0;
        cnt_r3 = 0;
    endtask

    initial begin
        int first_s;
        bit sb_v;
        bit cb_v;
        bit rs_v;
        rst     = 1'b1;
        set_btn = 1'b0;
        clr_btn = 1'b0;
        clr_counts();

        // Reset with both inputs high, then release reset.
        step(1, 1, 1);
        step(1, 1, 1);
        check("t1_reset_busy", int'(b1), 0);
        clr_counts();
        repeat (14) step(0, 1, 1);
        repeat (12) step(0, 0, 0);
        check("t1_r_pulses", cnt_r1, 1);
        check("t1_s_pulses", cnt_s1, 0);
        check("t1_conflicts", cnt_c1, 1);

        // Single held set press: latency and width.
        clr_counts();
        first_s = -1;
        for (int k = 1; k <= 12; k++) begin
            step(0, 1, 0);
            if (s1 && first_s < 0) first_s = k;
        end
        repeat (10) step(0, 0, 0);
        check("t2_latency", first_s, 1 + 6);
        check("t2_s_width", cnt_s1, 1);
        check("t2_r_none", cnt_r1, 0);

        // Three-cycle glitch must be filtered.
        clr_counts();
        repeat (3) step(0, 1, 0);
        repeat (12) step(0, 0, 0);
        check("t3_glitch_s", cnt_s1 + cnt_s3, 0);

        // Simultaneous press: clear wins.
        clr_counts();
        repeat (10) step(0, 1, 1);
        repeat (10) step(0, 0, 0);
        check("t4_r_pulses", cnt_r1, 1);
        check("t4_s_pulses", cnt_s1, 0);
        check("t4_conflicts", cnt_c1, 1);

        // Clear arriving during a long set pulse.
        clr_counts();
        repeat (2) step(0, 1, 0);
        repeat (15) step(0, 1, 1);
        repeat (15) step(0, 0, 0);
        check("t5_s_width_p3", cnt_s3, 3);
        check("t5_r_width_p3", cnt_r3, 3);

        // Reset during PULSE_R with a set pending.
        step(0, 0, 1);
        repeat (7) step(0, 1, 1);
        check("t6_r_active_p3", int'(r3), 1);
        step(1, 0, 0);
        check("t6_r_after_rst", int'(r3), 0);
        clr_counts();
        repeat (20) step(0, 0, 0);
        check("t6_no_s_p3", cnt_s3, 0);
        check("t6_no_s_p1", cnt_s1, 0);

        // Random bouncy inputs with occasional resets.
        sb_v = 1'b0;
        cb_v = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 7) == 0) sb_v = !sb_v;
            if ($urandom_range(0, 7) == 0) cb_v = !cb_v;
            rs_v = ($urandom_range(0, 299) == 0);
            step(rs_v, sb_v, cb_v);
        end
        repeat (20) step(0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
